// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between two writeback requesters:
// the ALU (port A) and the LSU (port B). Each requester uses a valid/ready
// handshake. The LSU has priority. A starvation guard force-grants the ALU
// after STARVE_LIMIT consecutive denied cycles. The write port is registered
// with one cycle of latency. A saturating conflict counter is provided for
// performance debug.
//
// Parameters:
//   STARVE_LIMIT  consecutive denied ALU cycles before a force grant (1..15)
//   CNT_W         width of the saturating conflict counter
//
// Ports:
//   clk           clock, all state on posedge
//   reset         asynchronous, active-high reset
//   flush         synchronous pipeline flush, blocks all transfers
//   a_valid       ALU writeback request
//   a_rd/a_data   ALU destination register / data
//   a_ready       ALU request accepted this cycle (combinational)
//   b_valid       LSU writeback request
//   b_rd/b_data   LSU destination register / data
//   b_ready       LSU request accepted this cycle (combinational)
//   rd            register-file write address (registered)
//   reg_wr_dat    register-file write data (registered)
//   regWrite      register-file write enable (registered)
//   conflict_cnt  saturating count of non-flush cycles with both valids high
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,

    input  logic             a_valid,
    input  logic [4:0]       a_rd,
    input  logic [31:0]      a_data,
    output logic             a_ready,

    input  logic             b_valid,
    input  logic [4:0]       b_rd,
    input  logic [31:0]      b_data,
    output logic             b_ready,

    output logic [4:0]       rd,
    output logic [31:0]      reg_wr_dat,
    output logic             regWrite,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int unsigned RD_W     = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STARVE_W = 4;

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

    // Writeback payload as presented to the register file.
    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_FORCE_A = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    wb_t                 wb_q, wb_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                a_xfer;
    logic                b_xfer;

    // Grant: LSU first in NORMAL, ALU only in FORCE_A; nothing during reset/flush.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset && !flush) begin
            unique case (state_q)
                ST_NORMAL: begin
                    b_ready = b_valid;
                    a_ready = a_valid & ~b_valid;
                end
                ST_FORCE_A: begin
                    a_ready = a_valid;
                    b_ready = 1'b0;
                end
                default: begin
                    a_ready = 1'b0;
                    b_ready = 1'b0;
                end
            endcase
        end
    end

    assign a_xfer = a_valid & a_ready;
    assign b_xfer = b_valid & b_ready;

    // Starvation tracking and arbitration mode.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (flush) begin
            state_d  = ST_NORMAL;
            starve_d = '0;
        end else if (!a_valid || a_xfer) begin
            state_d  = ST_NORMAL;
            starve_d = '0;
        end else if (state_q == ST_NORMAL) begin
            // ALU is waiting and lost this cycle.
            starve_d = starve_q + STARVE_W'(1);
            if (starve_d == STARVE_MAX) begin
                state_d = ST_FORCE_A;
            end
        end
    end

    // Write port: capture the winner; x0 updates address/data but never writes.
    always_comb begin
        wb_d = wb_q;
        we_d = 1'b0;
        if (b_xfer) begin
            wb_d.rd   = b_rd;
            wb_d.data = b_data;
            we_d      = (b_rd != RD_W'(0));
        end else if (a_xfer) begin
            wb_d.rd   = a_rd;
            wb_d.data = a_data;
            we_d      = (a_rd != RD_W'(0));
        end
    end

    // Conflict counter saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (!flush && a_valid && b_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
            wb_q     <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wb_q     <= wb_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd           = wb_q.rd;
    assign reg_wr_dat   = wb_q.data;
    assign regWrite     = we_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          a_valid, b_valid;
    logic [4:0]    a_rd, b_rd;
    logic [31:0]   a_data, b_data;
    logic          a_ready, b_ready;
    logic [4:0]    rd;
    logic [31:0]   reg_wr_dat;
    logic          regWrite;
    logic [CW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rd(rd), .reg_wr_dat(reg_wr_dat), .regWrite(regWrite),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] dat;
        int          cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: A wins if it has waited LIMIT lost cycles, else B first.
    int          denied;
    logic [4:0]  m_rd;
    logic [31:0] m_dat;
    int          m_cnt;
    bit          a_win, b_win;
    exp_t        mdl_e;

    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            denied = 0;
            m_rd   = '0;
            m_dat  = '0;
            m_cnt  = 0;
        end else begin
            a_win = 1'b0;
            b_win = 1'b0;
            if (!flush) begin
                if (a_valid && denied >= LIMIT) a_win = 1'b1;
                else if (b_valid)               b_win = 1'b1;
                else if (a_valid)               a_win = 1'b1;
            end
            chk("a_ready", 32'(a_ready), 32'(a_win));
            chk("b_ready", 32'(b_ready), 32'(b_win));
            if (!flush && a_valid && b_valid && m_cnt < CMAX) m_cnt++;
            denied = (!flush && a_valid && !a_win) ? denied + 1 : 0;
            mdl_e.we = 1'b0;
            if (b_win) begin
                m_rd = b_rd; m_dat = b_data; mdl_e.we = (b_rd != 5'd0);
            end else if (a_win) begin
                m_rd = a_rd; m_dat = a_data; mdl_e.we = (a_rd != 5'd0);
            end
            mdl_e.rd  = m_rd;
            mdl_e.dat = m_dat;
            mdl_e.cnt = m_cnt;
            sbq.push_back(mdl_e);
        end
    end

    // Monitor: compares the registered write port against the scoreboard.
    exp_t mon_e;
    always @(posedge clk) begin
        #2;
        if (!reset && sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("regWrite",     32'(regWrite),     32'(mon_e.we));
            chk("rd",           32'(rd),           32'(mon_e.rd));
            chk("reg_wr_dat",   reg_wr_dat,        mon_e.dat);
            chk("conflict_cnt", 32'(conflict_cnt), 32'(mon_e.cnt));
        end
    end

    // Handshake observation used only to retire driven requests.
    bit a_took, b_took;
    always @(negedge clk) begin
        a_took = a_valid & a_ready;
        b_took = b_valid & b_ready;
    end

    task automatic tick(input bit fl);
        @(posedge clk);
        #1;
        if (a_took) a_valid = 1'b0;
        if (b_took) b_valid = 1'b0;
        flush = fl;
    endtask

    task automatic issue_a(input logic [4:0] r, input logic [31:0] d);
        if (!a_valid) begin a_valid = 1'b1; a_rd = r; a_data = d; end
    endtask

    task automatic issue_b(input logic [4:0] r, input logic [31:0] d);
        if (!b_valid) begin b_valid = 1'b1; b_rd = r; b_data = d; end
    endtask

    function automatic logic [4:0] rnd_rd();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    task automatic rand_cycle();
        tick($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) != 0) issue_a(rnd_rd(), $urandom());
        if ($urandom_range(0, 4) != 0) issue_b(rnd_rd(), $urandom());
    endtask

    bit found;

    initial begin
        reset = 1'b1; flush = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_reg_wr_dat", reg_wr_dat, 32'd0);
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // A only
        tick(0); issue_a(5'd5, 32'h0000_1234);
        repeat (3) tick(0);

        // Simultaneous A and B
        tick(0); issue_a(5'd7, 32'hAAAA_0000); issue_b(5'd3, 32'hBBBB_0000);
        repeat (3) tick(0);

        // Starvation with both held high continuously
        tick(0); issue_a(5'd9, 32'h0A0A_0000); issue_b(5'd10, 32'h0B0B_0000);
        for (int i = 0; i < 6; i++) begin
            tick(0);
            issue_a(5'(11 + i), $urandom());
            issue_b(5'(20 + i), $urandom());
        end
        repeat (3) tick(0);

        // x0 write
        tick(0); issue_b(5'd0, 32'hFFFF_FFFF);
        repeat (2) tick(0);

        // Flush while in force-grant mode
        tick(0); issue_a(5'd12, 32'h1212_1212); issue_b(5'd13, 32'h1313_1313);
        for (int i = 0; i < 3; i++) begin
            tick(0); issue_b(5'(14 + i), $urandom());
        end
        tick(1); issue_b(5'd17, 32'h1717_1717);
        for (int i = 0; i < 6; i++) begin
            tick(0); issue_b(5'(18 + i), $urandom());
        end
        repeat (4) tick(0);

        // Randomized traffic
        repeat (600) rand_cycle();

        // Asynchronous reset mid-stream while a write is on the port
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            rand_cycle();
            if (regWrite === 1'b1) found = 1'b1;
        end
        chk("regWrite_seen_before_reset", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        a_valid = 1'b1; a_rd = rnd_rd(); a_data = $urandom();
        b_valid = 1'b1; b_rd = rnd_rd(); b_data = $urandom();
        #1;
        chk("async_regWrite", 32'(regWrite), 32'd0);
        chk("async_rd", 32'(rd), 32'd0);
        chk("async_reg_wr_dat", reg_wr_dat, 32'd0);
        chk("async_conflict_cnt", 32'(conflict_cnt), 32'd0);
        chk("async_a_ready", 32'(a_ready), 32'd0);
        chk("async_b_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("held_a_ready", 32'(a_ready), 32'd0);
        chk("held_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        repeat (300) rand_cycle();
        repeat (4) tick(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
